// File: rtl/dfi_cmd_seq.sv
// Closed-page DFI command sequencer: each request runs ACT -> RD/WR -> PRE, with optional periodic refresh.
// Define DFI_CMD_SEQ_REFRESH_EN to build the refresh interval counter and the REF command path.
module dfi_cmd_seq #(
   parameter int unsigned NUM_AD = 13,
   parameter int unsigned NUM_BA = 2,
   parameter int unsigned TRCD   = 2,
   parameter int unsigned TWR    = 3,
   parameter int unsigned TRP    = 2,
   parameter int unsigned TRFC   = 8,
   parameter int unsigned TREFI  = 780
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              cmd_valid,
   input  logic              cmd_we,
   input  logic [NUM_BA-1:0] cmd_bank,
   input  logic [NUM_AD-1:0] cmd_row,
   input  logic [NUM_AD-1:0] cmd_col,
   output logic              cmd_ready,
   output logic              cmd_done,
   output logic [NUM_AD-1:0] dfi_address_p0,
   output logic [NUM_BA-1:0] dfi_bank_p0,
   output logic              dfi_cs_n_p0,
   output logic              dfi_ras_n_p0,
   output logic              dfi_cas_n_p0,
   output logic              dfi_we_n_p0,
   output logic              dfi_wrdata_en_p1,
   output logic              dfi_rddata_en_p0
);

   localparam int unsigned TMAX_A = (TRCD > TWR) ? TRCD : TWR;
   localparam int unsigned TMAX_B = (TRP > TRFC) ? TRP : TRFC;
   localparam int unsigned TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
   localparam int unsigned CW     = (TMAX > 1) ? $clog2(TMAX) : 1;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;

   // Clears A10 (auto-precharge / all-bank select); all ones when the bus is narrower than 11 bits
   localparam logic [NUM_AD-1:0] A10_CLR = ~NUM_AD'(32'h400);

   if (TRCD < 1 || TWR < 1 || TRP < 1 || TRFC < 1 || TREFI < 1) begin : g_bad_timing
      $error("dfi_cmd_seq: timing parameters must be >= 1");
   end

   typedef enum logic [3:0] {
      S_IDLE, S_ACT, S_TRCD_WAIT, S_RW, S_TWR_WAIT,
      S_PRE, S_TRP_WAIT, S_REF, S_TRFC_WAIT
   } state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     wcnt, wcnt_nxt;
   logic              we_q;
   logic [NUM_BA-1:0] bank_q;
   logic [NUM_AD-1:0] col_q;
   logic              refresh_pending;

   logic              accept;
   logic              go_rw, go_pre, go_done;
   logic [3:0]        cmd_nxt;
   logic [NUM_AD-1:0] addr_nxt;
   logic [NUM_BA-1:0] bank_nxt;
   logic              wen_nxt, ren_nxt, done_nxt;

   assign cmd_ready = (state == S_IDLE) && !refresh_pending;

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      accept    = 1'b0;
      go_rw     = 1'b0;
      go_pre    = 1'b0;
      go_done   = 1'b0;
      cmd_nxt   = CMD_NOP;
      addr_nxt  = '0;
      bank_nxt  = '0;
      wen_nxt   = 1'b0;
      ren_nxt   = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (refresh_pending) begin
               state_nxt = S_REF;
               cmd_nxt   = CMD_REF;
            end else if (cmd_valid) begin
               accept    = 1'b1;
               state_nxt = S_ACT;
               cmd_nxt   = CMD_ACT;
               addr_nxt  = cmd_row;
               bank_nxt  = cmd_bank;
            end
         end
         S_ACT: begin
            if (TRCD == 1) go_rw = 1'b1;
            else begin
               state_nxt = S_TRCD_WAIT;
               wcnt_nxt  = CW'(TRCD - 2);
            end
         end
         S_TRCD_WAIT: begin
            if (wcnt == '0) go_rw = 1'b1;
            else            wcnt_nxt = wcnt - CW'(1);
         end
         S_RW: begin
            wen_nxt = we_q;
            ren_nxt = !we_q;
            if (TWR == 1) go_pre = 1'b1;
            else begin
               state_nxt = S_TWR_WAIT;
               wcnt_nxt  = CW'(TWR - 2);
            end
         end
         S_TWR_WAIT: begin
            if (wcnt == '0) go_pre = 1'b1;
            else            wcnt_nxt = wcnt - CW'(1);
         end
         S_PRE: begin
            if (TRP == 1) go_done = 1'b1;
            else begin
               state_nxt = S_TRP_WAIT;
               wcnt_nxt  = CW'(TRP - 2);
            end
         end
         S_TRP_WAIT: begin
            if (wcnt == '0) go_done = 1'b1;
            else            wcnt_nxt = wcnt - CW'(1);
         end
         S_REF: begin
            if (TRFC == 1) state_nxt = S_IDLE;
            else begin
               state_nxt = S_TRFC_WAIT;
               wcnt_nxt  = CW'(TRFC - 2);
            end
         end
         S_TRFC_WAIT: begin
            if (wcnt == '0) state_nxt = S_IDLE;
            else            wcnt_nxt = wcnt - CW'(1);
         end
         default: state_nxt = S_IDLE;
      endcase

      // Wait-state exits share the command they launch with the zero-wait path
      if (go_rw) begin
         state_nxt = S_RW;
         cmd_nxt   = we_q ? CMD_WR : CMD_RD;
         addr_nxt  = col_q & A10_CLR;
         bank_nxt  = bank_q;
      end
      if (go_pre) begin
         state_nxt = S_PRE;
         cmd_nxt   = CMD_PRE;
         bank_nxt  = bank_q;
      end
      if (go_done) begin
         state_nxt = S_IDLE;
         done_nxt  = 1'b1;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state            <= S_IDLE;
         wcnt             <= '0;
         we_q             <= 1'b0;
         bank_q           <= '0;
         col_q            <= '0;
         {dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= CMD_NOP;
         dfi_address_p0   <= '0;
         dfi_bank_p0      <= '0;
         dfi_wrdata_en_p1 <= 1'b0;
         dfi_rddata_en_p0 <= 1'b0;
         cmd_done         <= 1'b0;
      end else begin
         state            <= state_nxt;
         wcnt             <= wcnt_nxt;
         if (accept) begin
            we_q   <= cmd_we;
            bank_q <= cmd_bank;
            col_q  <= cmd_col;
         end
         {dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} <= cmd_nxt;
         dfi_address_p0   <= addr_nxt;
         dfi_bank_p0      <= bank_nxt;
         dfi_wrdata_en_p1 <= wen_nxt;
         dfi_rddata_en_p0 <= ren_nxt;
         cmd_done         <= done_nxt;
      end
   end

`ifdef DFI_CMD_SEQ_REFRESH_EN
   localparam int unsigned RC_W = (TREFI > 1) ? $clog2(TREFI) : 1;

   logic [RC_W-1:0] ref_cnt;
   logic            ref_wrap;

   assign ref_wrap = (ref_cnt == RC_W'(TREFI - 1));

   // A wrap while already pending leaves a single request; a wrap on the issue cycle starts a new one
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         ref_cnt         <= '0;
         refresh_pending <= 1'b0;
      end else begin
         ref_cnt <= ref_wrap ? '0 : ref_cnt + RC_W'(1);
         if (ref_wrap)
            refresh_pending <= 1'b1;
         else if (state == S_IDLE && refresh_pending)
            refresh_pending <= 1'b0;
      end
   end
`else
   assign refresh_pending = 1'b0;
`endif

endmodule

// File: tb/tb_dfi_cmd_seq.sv
// Scoreboard bench for dfi_cmd_seq: expected DFI events are queued at request time and matched as they appear.
// Refresh scenarios are selected by DFI_CMD_SEQ_REFRESH_EN, matching the DUT build.
module tb_dfi_cmd_seq;

   localparam int unsigned NUM_AD = 13;
   localparam int unsigned NUM_BA = 2;

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_we = 1'b0;
   logic [NUM_BA-1:0] cmd_bank = '0;
   logic [NUM_AD-1:0] cmd_row = '0;
   logic [NUM_AD-1:0] cmd_col = '0;
   logic              cmd_ready, cmd_done;
   logic [NUM_AD-1:0] dfi_address_p0;
   logic [NUM_BA-1:0] dfi_bank_p0;
   logic              dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0;
   logic              dfi_wrdata_en_p1, dfi_rddata_en_p0;

   dfi_cmd_seq #(
      .NUM_AD(NUM_AD), .NUM_BA(NUM_BA),
      .TRCD(2), .TWR(3), .TRP(2), .TRFC(8), .TREFI(100)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .cmd_valid(cmd_valid), .cmd_we(cmd_we),
      .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
      .cmd_ready(cmd_ready), .cmd_done(cmd_done),
      .dfi_address_p0(dfi_address_p0), .dfi_bank_p0(dfi_bank_p0),
      .dfi_cs_n_p0(dfi_cs_n_p0), .dfi_ras_n_p0(dfi_ras_n_p0),
      .dfi_cas_n_p0(dfi_cas_n_p0), .dfi_we_n_p0(dfi_we_n_p0),
      .dfi_wrdata_en_p1(dfi_wrdata_en_p1), .dfi_rddata_en_p0(dfi_rddata_en_p0)
   );

   always #5 sys_clk = ~sys_clk;

   typedef enum int { E_ACT, E_RD, E_WR, E_PRE, E_REF, E_WEN, E_REN, E_DONE, E_BAD } kind_t;
   typedef struct { int cyc; kind_t kind; int addr; int bank; } ev_t;

   ev_t exp_q[$];
   ev_t obs_q[$];
   int  edges = 0;
   int  t0 = 0;
   int  n_tests = 0;
   int  n_fail = 0;

   always @(posedge sys_clk) edges <= edges + 1;

   function automatic int cyc_now();
      return edges - t0;
   endfunction

   task automatic push_exp(input int cyc, input kind_t kind, input int addr, input int bank);
      ev_t e;
      e.cyc = cyc; e.kind = kind; e.addr = addr; e.bank = bank;
      exp_q.push_back(e);
   endtask

   task automatic set_req(input logic v, input logic we, input int bank, input int row, input int col);
      cmd_valid = v;
      cmd_we    = we;
      cmd_bank  = NUM_BA'(bank);
      cmd_row   = NUM_AD'(row);
      cmd_col   = NUM_AD'(col);
   endtask

   // Cycle 0 is the first cycle after the edge that last sampled reset high
   task automatic do_reset();
      sys_rst = 1'b1;
      set_req(1'b0, 1'b0, 0, 0, 0);
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      t0 = edges;
      exp_q.delete();
   endtask

   task automatic observe();
      logic [3:0] c;
      ev_t e;
      obs_q.delete();
      c = {dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0};
      e.cyc  = cyc_now();
      e.addr = int'(dfi_address_p0);
      e.bank = int'(dfi_bank_p0);
      e.kind = E_BAD;
      case (c)
         4'b0111: if (dfi_address_p0 !== '0 || dfi_bank_p0 !== '0) obs_q.push_back(e);
         4'b0011: begin e.kind = E_ACT; obs_q.push_back(e); end
         4'b0101: begin e.kind = E_RD;  obs_q.push_back(e); end
         4'b0100: begin e.kind = E_WR;  obs_q.push_back(e); end
         4'b0010: begin e.kind = E_PRE; obs_q.push_back(e); end
         4'b0001: begin e.kind = E_REF; obs_q.push_back(e); end
         default: obs_q.push_back(e);
      endcase
      e.addr = 0;
      e.bank = 0;
      if (dfi_wrdata_en_p1 !== 1'b0) begin e.kind = E_WEN;  obs_q.push_back(e); end
      if (dfi_rddata_en_p0 !== 1'b0) begin e.kind = E_REN;  obs_q.push_back(e); end
      if (cmd_done !== 1'b0)         begin e.kind = E_DONE; obs_q.push_back(e); end
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      set_req(1'b1, 1'b1, 3, 'h1fff, 'h1fff);
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      n_tests++;
      if ({dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0} !== 4'b0111) begin
         n_fail++;
         $display("FAIL reset_cmd: got %b, required 0111",
                  {dfi_cs_n_p0, dfi_ras_n_p0, dfi_cas_n_p0, dfi_we_n_p0});
      end
      n_tests++;
      if (dfi_address_p0 !== '0 || dfi_bank_p0 !== '0) begin
         n_fail++;
         $display("FAIL reset_addr: got a=%h b=%0d, required a=0 b=0", dfi_address_p0, dfi_bank_p0);
      end
      n_tests++;
      if ({dfi_wrdata_en_p1, dfi_rddata_en_p0, cmd_done} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got wen/ren/done=%b, required 000",
                  {dfi_wrdata_en_p1, dfi_rddata_en_p0, cmd_done});
      end
      n_tests++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b, required 1", cmd_ready);
      end
      set_req(1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic test_write();
      ev_t x;
      logic exp_ready;
      do_reset();
      for (int c = 0; c <= 25; c++) begin
         if (c == 10) begin
            set_req(1'b1, 1'b1, 2, 'h0dbe, 'h0010);
            push_exp(11, E_ACT, 'h0dbe, 2);
            push_exp(13, E_WR, 'h0010, 2);
            push_exp(14, E_WEN, 0, 0);
            push_exp(16, E_PRE, 0, 2);
            push_exp(18, E_DONE, 0, 0);
         end
         if (c == 11) set_req(1'b0, 1'b0, 1, 'h1fff, 'h1fff);
         @(negedge sys_clk);
         exp_ready = (c <= 10) || (c >= 18);
         n_tests++;
         if (cmd_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL write_ready cyc %0d: got %b, required %b", c, cmd_ready, exp_ready);
         end
         observe();
         foreach (obs_q[i]) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL write_seq cyc %0d: got %s a=%h b=%0d, required no event",
                        c, obs_q[i].kind.name(), obs_q[i].addr, obs_q[i].bank);
            end else begin
               x = exp_q.pop_front();
               if (obs_q[i].cyc !== x.cyc || obs_q[i].kind !== x.kind ||
                   obs_q[i].addr !== x.addr || obs_q[i].bank !== x.bank) begin
                  n_fail++;
                  $display("FAIL write_seq: got %s@%0d a=%h b=%0d, required %s@%0d a=%h b=%0d",
                           obs_q[i].kind.name(), obs_q[i].cyc, obs_q[i].addr, obs_q[i].bank,
                           x.kind.name(), x.cyc, x.addr, x.bank);
               end
            end
         end
         @(posedge sys_clk); #1;
      end
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL write_missing: got %0d events outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_read();
      ev_t x;
      logic exp_ready;
      do_reset();
      for (int c = 0; c <= 42; c++) begin
         if (c == 30) begin
            set_req(1'b1, 1'b0, 1, 'h1234, 'h0008);
            push_exp(31, E_ACT, 'h1234, 1);
            push_exp(33, E_RD, 'h0008, 1);
            push_exp(34, E_REN, 0, 0);
            push_exp(36, E_PRE, 0, 1);
            push_exp(38, E_DONE, 0, 0);
         end
         if (c == 31) set_req(1'b0, 1'b1, 3, 'h0f0f, 'h0400);
         @(negedge sys_clk);
         exp_ready = (c <= 30) || (c >= 38);
         n_tests++;
         if (cmd_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL read_ready cyc %0d: got %b, required %b", c, cmd_ready, exp_ready);
         end
         observe();
         foreach (obs_q[i]) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL read_seq cyc %0d: got %s a=%h b=%0d, required no event",
                        c, obs_q[i].kind.name(), obs_q[i].addr, obs_q[i].bank);
            end else begin
               x = exp_q.pop_front();
               if (obs_q[i].cyc !== x.cyc || obs_q[i].kind !== x.kind ||
                   obs_q[i].addr !== x.addr || obs_q[i].bank !== x.bank) begin
                  n_fail++;
                  $display("FAIL read_seq: got %s@%0d a=%h b=%0d, required %s@%0d a=%h b=%0d",
                           obs_q[i].kind.name(), obs_q[i].cyc, obs_q[i].addr, obs_q[i].bank,
                           x.kind.name(), x.cyc, x.addr, x.bank);
               end
            end
         end
         @(posedge sys_clk); #1;
      end
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL read_missing: got %0d events outstanding, required 0", exp_q.size());
      end
   endtask

   // Two requests with cmd_valid held high; column A10 set in the request must be cleared on the bus
   task automatic test_back_to_back();
      ev_t x;
      do_reset();
      for (int c = 0; c <= 26; c++) begin
         if (c == 5) begin
            set_req(1'b1, 1'b1, 3, 'h0aaa, 'h0555);
            push_exp(6, E_ACT, 'h0aaa, 3);
            push_exp(8, E_WR, 'h0155, 3);
            push_exp(9, E_WEN, 0, 0);
            push_exp(11, E_PRE, 0, 3);
            push_exp(13, E_DONE, 0, 0);
            push_exp(14, E_ACT, 'h0001, 0);
            push_exp(16, E_RD, 'h1803, 0);
            push_exp(17, E_REN, 0, 0);
            push_exp(19, E_PRE, 0, 0);
            push_exp(21, E_DONE, 0, 0);
         end
         if (c == 6)  set_req(1'b1, 1'b0, 0, 'h0001, 'h1c03);
         if (c == 14) set_req(1'b0, 1'b1, 2, 'h1111, 'h0222);
         @(negedge sys_clk);
         if (c == 13) begin
            n_tests++;
            if (cmd_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_ready cyc 13: got %b, required 1", cmd_ready);
            end
         end
         observe();
         foreach (obs_q[i]) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_seq cyc %0d: got %s a=%h b=%0d, required no event",
                        c, obs_q[i].kind.name(), obs_q[i].addr, obs_q[i].bank);
            end else begin
               x = exp_q.pop_front();
               if (obs_q[i].cyc !== x.cyc || obs_q[i].kind !== x.kind ||
                   obs_q[i].addr !== x.addr || obs_q[i].bank !== x.bank) begin
                  n_fail++;
                  $display("FAIL b2b_seq: got %s@%0d a=%h b=%0d, required %s@%0d a=%h b=%0d",
                           obs_q[i].kind.name(), obs_q[i].cyc, obs_q[i].addr, obs_q[i].bank,
                           x.kind.name(), x.cyc, x.addr, x.bank);
               end
            end
         end
         @(posedge sys_clk); #1;
      end
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL b2b_missing: got %0d events outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset_abort();
      ev_t x;
      do_reset();
      for (int c = 0; c <= 65; c++) begin
         if (c == 50) begin
            set_req(1'b1, 1'b1, 3, 'h0123, 'h0040);
            push_exp(51, E_ACT, 'h0123, 3);
         end
         if (c == 51) begin
            set_req(1'b0, 1'b0, 0, 0, 0);
            sys_rst = 1'b1;
         end
         if (c == 52) sys_rst = 1'b0;
         @(negedge sys_clk);
         if (c == 51 || c == 52) begin
            n_tests++;
            if (cmd_ready !== (c == 52)) begin
               n_fail++;
               $display("FAIL abort_ready cyc %0d: got %b, required %b", c, cmd_ready, (c == 52));
            end
         end
         observe();
         foreach (obs_q[i]) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL abort_seq cyc %0d: got %s a=%h b=%0d, required no event",
                        c, obs_q[i].kind.name(), obs_q[i].addr, obs_q[i].bank);
            end else begin
               x = exp_q.pop_front();
               if (obs_q[i].cyc !== x.cyc || obs_q[i].kind !== x.kind ||
                   obs_q[i].addr !== x.addr || obs_q[i].bank !== x.bank) begin
                  n_fail++;
                  $display("FAIL abort_seq: got %s@%0d a=%h b=%0d, required %s@%0d a=%h b=%0d",
                           obs_q[i].kind.name(), obs_q[i].cyc, obs_q[i].addr, obs_q[i].bank,
                           x.kind.name(), x.cyc, x.addr, x.bank);
               end
            end
         end
         @(posedge sys_clk); #1;
      end
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL abort_missing: got %0d events outstanding, required 0", exp_q.size());
      end
   endtask

`ifdef DFI_CMD_SEQ_REFRESH_EN
   task automatic test_refresh_idle();
      ev_t x;
      logic exp_ready;
      do_reset();
      push_exp(101, E_REF, 0, 0);
      push_exp(201, E_REF, 0, 0);
      for (int c = 0; c <= 212; c++) begin
         @(negedge sys_clk);
         exp_ready = !((c >= 100 && c <= 108) || (c >= 200 && c <= 208));
         n_tests++;
         if (cmd_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL ref_idle_ready cyc %0d: got %b, required %b", c, cmd_ready, exp_ready);
         end
         observe();
         foreach (obs_q[i]) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL ref_idle_seq cyc %0d: got %s a=%h b=%0d, required no event",
                        c, obs_q[i].kind.name(), obs_q[i].addr, obs_q[i].bank);
            end else begin
               x = exp_q.pop_front();
               if (obs_q[i].cyc !== x.cyc || obs_q[i].kind !== x.kind ||
                   obs_q[i].addr !== x.addr || obs_q[i].bank !== x.bank) begin
                  n_fail++;
                  $display("FAIL ref_idle_seq: got %s@%0d a=%h b=%0d, required %s@%0d a=%h b=%0d",
                           obs_q[i].kind.name(), obs_q[i].cyc, obs_q[i].addr, obs_q[i].bank,
                           x.kind.name(), x.cyc, x.addr, x.bank);
               end
            end
         end
         @(posedge sys_clk); #1;
      end
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL ref_idle_missing: got %0d events outstanding, required 0", exp_q.size());
      end
   endtask

   // Request raised while refresh is pending must wait out REF and tRFC
   task automatic test_refresh_priority();
      ev_t x;
      do_reset();
      for (int c = 0; c <= 122; c++) begin
         if (c == 100) begin
            set_req(1'b1, 1'b1, 0, 'h0777, 'h0020);
            push_exp(101, E_REF, 0, 0);
            push_exp(110, E_ACT, 'h0777, 0);
            push_exp(112, E_WR, 'h0020, 0);
            push_exp(113, E_WEN, 0, 0);
            push_exp(115, E_PRE, 0, 0);
            push_exp(117, E_DONE, 0, 0);
         end
         if (c == 110) set_req(1'b0, 1'b0, 0, 0, 0);
         @(negedge sys_clk);
         if (c == 100 || c == 108 || c == 109) begin
            n_tests++;
            if (cmd_ready !== (c == 109)) begin
               n_fail++;
               $display("FAIL ref_prio_ready cyc %0d: got %b, required %b", c, cmd_ready, (c == 109));
            end
         end
         observe();
         foreach (obs_q[i]) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL ref_prio_seq cyc %0d: got %s a=%h b=%0d, required no event",
                        c, obs_q[i].kind.name(), obs_q[i].addr, obs_q[i].bank);
            end else begin
               x = exp_q.pop_front();
               if (obs_q[i].cyc !== x.cyc || obs_q[i].kind !== x.kind ||
                   obs_q[i].addr !== x.addr || obs_q[i].bank !== x.bank) begin
                  n_fail++;
                  $display("FAIL ref_prio_seq: got %s@%0d a=%h b=%0d, required %s@%0d a=%h b=%0d",
                           obs_q[i].kind.name(), obs_q[i].cyc, obs_q[i].addr, obs_q[i].bank,
                           x.kind.name(), x.cyc, x.addr, x.bank);
               end
            end
         end
         @(posedge sys_clk); #1;
      end
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL ref_prio_missing: got %0d events outstanding, required 0", exp_q.size());
      end
   endtask

   // Refresh falling due mid-transaction is deferred until the sequencer is back in IDLE
   task automatic test_refresh_during_txn();
      ev_t x;
      do_reset();
      for (int c = 0; c <= 115; c++) begin
         if (c == 95) begin
            set_req(1'b1, 1'b1, 1, 'h0042, 'h0011);
            push_exp(96, E_ACT, 'h0042, 1);
            push_exp(98, E_WR, 'h0011, 1);
            push_exp(99, E_WEN, 0, 0);
            push_exp(101, E_PRE, 0, 1);
            push_exp(103, E_DONE, 0, 0);
            push_exp(104, E_REF, 0, 0);
         end
         if (c == 96) set_req(1'b0, 1'b0, 0, 0, 0);
         @(negedge sys_clk);
         if (c == 103 || c == 111 || c == 112) begin
            n_tests++;
            if (cmd_ready !== (c == 112)) begin
               n_fail++;
               $display("FAIL ref_txn_ready cyc %0d: got %b, required %b", c, cmd_ready, (c == 112));
            end
         end
         observe();
         foreach (obs_q[i]) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL ref_txn_seq cyc %0d: got %s a=%h b=%0d, required no event",
                        c, obs_q[i].kind.name(), obs_q[i].addr, obs_q[i].bank);
            end else begin
               x = exp_q.pop_front();
               if (obs_q[i].cyc !== x.cyc || obs_q[i].kind !== x.kind ||
                   obs_q[i].addr !== x.addr || obs_q[i].bank !== x.bank) begin
                  n_fail++;
                  $display("FAIL ref_txn_seq: got %s@%0d a=%h b=%0d, required %s@%0d a=%h b=%0d",
                           obs_q[i].kind.name(), obs_q[i].cyc, obs_q[i].addr, obs_q[i].bank,
                           x.kind.name(), x.cyc, x.addr, x.bank);
               end
            end
         end
         @(posedge sys_clk); #1;
      end
      n_tests++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL ref_txn_missing: got %0d events outstanding, required 0", exp_q.size());
      end
   endtask
`else
   task automatic test_no_refresh();
      int ready_low;
      int events;
      ready_low = 0;
      events = 0;
      do_reset();
      for (int c = 0; c < 1000; c++) begin
         @(negedge sys_clk);
         if (cmd_ready !== 1'b1) ready_low++;
         observe();
         events += obs_q.size();
         @(posedge sys_clk); #1;
      end
      n_tests++;
      if (ready_low !== 0) begin
         n_fail++;
         $display("FAIL noref_ready: got %0d cycles low, required 0", ready_low);
      end
      n_tests++;
      if (events !== 0) begin
         n_fail++;
         $display("FAIL noref_events: got %0d DFI events, required 0", events);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_abort();
`ifdef DFI_CMD_SEQ_REFRESH_EN
      test_refresh_idle();
      test_refresh_priority();
      test_refresh_during_txn();
`else
      test_no_refresh();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
